// File: rtl/shared_timer_scheduler_if.sv
// shared_timer_scheduler_if
//   Bundles the requester-side signals of the shared timer scheduler.
//   req   : level request per requester, held until done or dropped to abort
//   delay : packed per-requester delay, requester i at [i*DELAY_W +: DELAY_W]
//   grant : one-hot owner of the shared counter, zero when idle
//   done  : one-cycle pulse to the requester whose delay expired
//   busy  : high while any grant bit is high
//   master drives req/delay, slave (the scheduler) drives grant/done/busy.
interface shared_timer_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DELAY_W = 8
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*DELAY_W-1:0] delay;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;

  modport master (output req, delay, input grant, done, busy);
  modport slave  (input req, delay, output grant, done, busy);
endinterface

// File: rtl/shared_timer_scheduler.sv
// shared_timer_scheduler
//   Round-robin arbiter sharing one delay counter among NUM_REQ requesters.
//   The winner's delay (0 treated as 1) is counted in base ticks of CLK_COUNT
//   clocks; on expiry the owner gets a one-cycle done pulse. Dropping req
//   while owning the counter aborts without done.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : shared_timer_scheduler_if slave (req, delay in; grant, done, busy out)
module shared_timer_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DELAY_W   = 8,
  parameter int unsigned CLK_COUNT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  shared_timer_scheduler_if.slave bus
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned PW = (CLK_COUNT > 1) ? $clog2(CLK_COUNT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      own;
  logic [DELAY_W-1:0] remain;
  logic [PW-1:0]      presc;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               busy_q;

  logic               arb_found;
  logic [IW-1:0]      arb_idx;
  logic [IW-1:0]      cand;
  logic [IW-1:0]      arb_next;
  logic [DELAY_W-1:0] arb_delay;

  // Rotating search starting at ptr; first set req bit wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IW'((32'(ptr) + k) % NUM_REQ);
      if (!arb_found && bus.req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    arb_next  = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    arb_delay = bus.delay[arb_idx*DELAY_W +: DELAY_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      own     <= '0;
      remain  <= '0;
      presc   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (arb_found) begin
            state   <= S_RUN;
            own     <= arb_idx;
            ptr     <= arb_next;
            remain  <= (arb_delay == '0) ? DELAY_W'(1) : arb_delay;
            presc   <= '0;
            grant_q <= NUM_REQ'(1) << arb_idx;
            busy_q  <= 1'b1;
          end else begin
            state   <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // Abort takes priority over a coinciding final tick.
          if (!bus.req[own]) begin
            state   <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (presc == PW'(CLK_COUNT - 1)) begin
            presc <= '0;
            if (remain == DELAY_W'(1)) begin
              state       <= S_DONE;
              grant_q     <= '0;
              busy_q      <= 1'b0;
              done_q[own] <= 1'b1;
            end else begin
              remain <= remain - 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_shared_timer_scheduler.sv
// tb_shared_timer_scheduler
//   Three schedulers (CLK_COUNT 1, 2, 3) share one req/delay stimulus and are
//   compared every cycle against a cycle-countdown reference model.
module tb_shared_timer_scheduler;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] delay;

  always #5 clk = ~clk;

  shared_timer_scheduler_if #(.NUM_REQ(N), .DELAY_W(DW)) bus1 ();
  shared_timer_scheduler_if #(.NUM_REQ(N), .DELAY_W(DW)) bus2 ();
  shared_timer_scheduler_if #(.NUM_REQ(N), .DELAY_W(DW)) bus3 ();

  assign bus1.req = req;  assign bus1.delay = delay;
  assign bus2.req = req;  assign bus2.delay = delay;
  assign bus3.req = req;  assign bus3.delay = delay;

  shared_timer_scheduler #(.NUM_REQ(N), .DELAY_W(DW), .CLK_COUNT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  shared_timer_scheduler #(.NUM_REQ(N), .DELAY_W(DW), .CLK_COUNT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  shared_timer_scheduler #(.NUM_REQ(N), .DELAY_W(DW), .CLK_COUNT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [N-1:0] g [3];
  logic [N-1:0] d [3];
  logic         b [3];
  assign g[0] = bus1.grant; assign d[0] = bus1.done; assign b[0] = bus1.busy;
  assign g[1] = bus2.grant; assign d[1] = bus2.done; assign b[1] = bus2.busy;
  assign g[2] = bus3.grant; assign d[2] = bus3.done; assign b[2] = bus3.busy;

  // Reference model: owner index (-1 none), grant cycles left, pointer.
  int           cc    [3] = '{1, 2, 3};
  int           m_own [3] = '{-1, -1, -1};
  int           m_left[3] = '{0, 0, 0};
  int           m_ptr [3] = '{0, 0, 0};
  logic [N-1:0] m_done[3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    int idx;
    int dv;
    bit found;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_own[k] = -1; m_left[k] = 0; m_ptr[k] = 0; m_done[k] = '0;
      end else begin
        m_done[k] = '0;
        if (m_own[k] >= 0) begin
          if (!req[m_own[k]]) begin
            m_own[k] = -1;
          end else begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_done[k][m_own[k]] = 1'b1;
              m_own[k] = -1;
            end
          end
        end else begin
          found = 0;
          for (int j = 0; j < N; j++) begin
            idx = (m_ptr[k] + j) % N;
            if (!found && req[idx]) begin
              found = 1;
              dv = int'(delay[idx*DW +: DW]);
              m_own[k]  = idx;
              m_left[k] = ((dv == 0) ? 1 : dv) * cc[k];
              m_ptr[k]  = (idx + 1) % N;
            end
          end
        end
      end
    end
  endtask

  // One clock: model follows the inputs present at the edge, outputs checked #1 later.
  task automatic step();
    logic [N-1:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      eg = '0;
      if (m_own[k] >= 0) eg[m_own[k]] = 1'b1;
      chk("grant", k, 32'(g[k]), 32'(eg));
      chk("done",  k, 32'(d[k]), 32'(m_done[k]));
      chk("busy",  k, 32'(b[k]), 32'(m_own[k] >= 0));
    end
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; req = '0; delay = '0;
    step(); step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_grant", k, 32'(g[k]), 32'd0);
      chk("rst_busy",  k, 32'(b[k]), 32'd0);
    end
    rst = 1'b0;

    // Single request, delay 5: CLK_COUNT=3 instance granted 11..25, done at 26.
    delay[2*DW +: DW] = 8'd5;
    for (int c = 0; c < 40; c++) begin
      req = (c >= 10 && c <= 25) ? 4'b0100 : 4'b0000;
      step();
      if (c + 1 >= 11 && c + 1 <= 25) chk("sr_grant", 2, 32'(g[2]), 32'h4);
      if (c + 1 == 26) begin
        chk("sr_done",  2, 32'(d[2]), 32'h4);
        chk("sr_busy",  2, 32'(b[2]), 32'h0);
        chk("sr_grant0", 2, 32'(g[2]), 32'h0);
      end
    end

    // Delay 0 then delay 1 on requester 0 (CLK_COUNT=1 instance).
    idle(40);
    req = 4'b0001; delay[0 +: DW] = 8'd0;
    step(); chk("d0_grant", 0, 32'(g[0]), 32'h1);
    delay[0 +: DW] = 8'd1;
    step(); chk("d0_done", 0, 32'(d[0]), 32'h1); chk("d0_gz", 0, 32'(g[0]), 32'h0);
    step(); chk("d1_grant", 0, 32'(g[0]), 32'h1);
    step(); chk("d1_done", 0, 32'(d[0]), 32'h1); chk("d1_gz", 0, 32'(g[0]), 32'h0);
    req = '0;
    step(); chk("d1_idle", 0, 32'(g[0]), 32'h0);

    // Round robin with all requesters held, delay 2.
    idle(40);
    for (int i = 0; i < N; i++) delay[i*DW +: DW] = 8'd2;
    req = 4'b1111;
    for (int i = 0; i < 45; i++) step();

    // Priority after pointer: serve 1, then 0 wins ahead of 1.
    idle(40);
    delay[0 +: DW] = 8'd1; delay[DW +: DW] = 8'd1;
    req = 4'b0010;
    step(); chk("pp_grant1", 0, 32'(g[0]), 32'h2);
    req = 4'b0011;
    step(); chk("pp_done1", 0, 32'(d[0]), 32'h2);
    step(); chk("pp_grant0", 0, 32'(g[0]), 32'h1);

    // Abort: requester 1 (delay 10) dropped 4 cycles in; pending 3 follows.
    idle(40);
    rst = 1'b1; step(); rst = 1'b0;
    delay[DW +: DW] = 8'd10; delay[3*DW +: DW] = 8'd3;
    req = 4'b1010;
    step(); chk("ab_grant", 1, 32'(g[1]), 32'h2);
    step(); step(); step();
    req = 4'b1000;
    step(); chk("ab_gz", 1, 32'(g[1]), 32'h0); chk("ab_nodone", 1, 32'(d[1]), 32'h0);
    step(); chk("ab_next", 1, 32'(g[1]), 32'h8);

    // Reset mid-run with req held: requester 1 granted right after reset.
    idle(40);
    delay[DW +: DW] = 8'd5;
    req = 4'b1010;
    step(); step(); step();
    rst = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("mr_grant", k, 32'(g[k]), 32'h0);
      chk("mr_done",  k, 32'(d[k]), 32'h0);
      chk("mr_busy",  k, 32'(b[k]), 32'h0);
    end
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) chk("mr_regrant", k, 32'(g[k]), 32'h2);

    // Random phase: sparse req toggles, delays rewritten mid-run, rare resets.
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ N'(1 << $urandom_range(0, N - 1));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) delay[i*DW +: DW] = DW'($urandom_range(0, 6));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shared_timer_scheduler.md
# shared_timer_scheduler

Round-robin scheduler that shares one delay counter among `NUM_REQ` requesters. Each requester asks for a delay of `D` base ticks. The block grants the shared counter to one requester at a time and runs a `CLK_COUNT` prescaler to generate the base ticks. It pulses that requester's `done` when the delay expires. It sits between protocol FSMs that need timeouts or hold-offs and the single physical counter they share, so the design does not instantiate one timer per FSM.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DELAY_W`, default 8: width of each requested delay, in base ticks.
- `CLK_COUNT`, default 1: clock cycles per base tick, ≥1.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  `NUM_REQ`: level request per requester; held until `done` or dropped to abort.
- `delay`  in  `NUM_REQ*DELAY_W`: requester i's delay at bits `[i*DELAY_W +: DELAY_W]`; sampled only at grant.
- `grant`  out  `NUM_REQ`: one-hot owner of the counter; all zero when idle.
- `done`  out  `NUM_REQ`: one-cycle pulse to the requester whose delay expired.
- `busy`  out  1: high while any `grant` bit is high.

## Operation
- **States.**
  - IDLE: no owner.
  - RUN: counter owned and counting.
  - DONE: one cycle; `done` pulsed, no owner.
- **Arbitration.** Runs in IDLE and in DONE.
  - Search starts at pointer `ptr` and wraps modulo `NUM_REQ`; the first `req` bit set wins.
  - Winner i: latch `delay_i`, set `grant[i]`, go to RUN, set `ptr` = (i+1) mod `NUM_REQ`.
  - No `req` set: go to or stay in IDLE.
- **Delay 0.** Treated as delay 1.
- **RUN counting.**
  - Prescaler clears on entry to RUN and counts 0..`CLK_COUNT`-1; a base tick occurs when it reaches `CLK_COUNT`-1.
  - The remaining-tick count is loaded with the latched delay and decrements on each base tick.
  - When the final tick occurs: go to DONE, clear `grant`, pulse `done[i]`.
- **Abort.** `req[owner]` low in any RUN cycle means:
  - next cycle IDLE, `grant` cleared, no `done`;
  - `ptr` keeps the value set at grant.
- **Other requesters.** Changes on other `req` bits never disturb the current RUN.
- **Re-request.** A requester that keeps `req` high through its own DONE is re-eligible, at lowest priority.
- **Width rules.**
  - Remaining-tick counter is `DELAY_W` bits; prescaler is `$clog2(CLK_COUNT)` bits, minimum 1.
  - No overflow is possible: the maximum run is (2^`DELAY_W`-1)·`CLK_COUNT` cycles.
- **Reset.** Synchronous, overrides everything including mid-RUN: state IDLE, `grant`=0, `done`=0, `busy`=0, `ptr`=0, counters 0.

## Timing
- `req[i]` high in an arbitration cycle at edge N gives `grant[i]`=1 and `busy`=1 from cycle N+1.
- Grant is held for exactly max(D,1)·`CLK_COUNT` cycles: cycles N+1 .. N+max(D,1)·`CLK_COUNT`.
- `done[i]` is high in cycle N+1+max(D,1)·`CLK_COUNT` only; in that cycle `grant`=0 and `busy`=0.
- **Back-to-back.** The DONE cycle arbitrates, so the next grant starts the cycle after `done`. Minimum gap between grants is 1 cycle.
- **Abort timing.** `req[owner]` low at edge M gives `grant`=0 at M+1. The cycle M+1 is IDLE and arbitrates, so the next grant is at M+2 at the earliest.
- **Fixed relations.**
  - `done` and `grant` are never high in the same cycle.
  - `grant` is never high for more than one bit.
  - Every output is registered and has no combinational path from inputs.

## Test plan
- **Single request.** `NUM_REQ`=4, `CLK_COUNT`=3, `DELAY_W`=8; `req[2]` set at cycle 10 with delay 5 → `grant`=4'b0100 in cycles 11..25, `done[2]` pulse in cycle 26, `busy` low in cycle 26.
- **Delay 0 and 1.** `CLK_COUNT`=1; delay 0 then delay 1 on `req[0]` → both give a 1-cycle grant, then a 1-cycle `done[0]` pulse.
- **Round-robin fairness.** `CLK_COUNT`=1, delays 2, all `req`=4'b1111 held and re-asserted → grant order 0,1,2,3,0; each grant 2 cycles; `done` every 3 cycles.
- **Priority after pointer.** `ptr`=2 after serving requester 1, then `req`=4'b0011 → requester 0 is granted before requester 1 re-wins.
- **Abort.** `req[1]` granted with delay 10, `CLK_COUNT`=2; `req[1]` dropped 4 cycles into the grant → `grant`=0 next cycle, no `done`; a pending `req[3]` is granted the following cycle.
- **Reset mid-RUN.** `rst` asserted for 1 cycle during a grant → next cycle all outputs 0. With `req`=4'b1010 still high, requester 1 is granted the cycle after `rst` drops (`ptr`=0).
